// File: rtl/mem_arb_defs.sv
// Shared definitions for the data memory arbiter: FSM encodings, port
// indices, widths and a small grant-to-one-hot helper.
package mem_arb_defs;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 3;   // holds LATENCY up to 7

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Convert a granted port index into its ack bit position.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational grant, registered record of
// the most recent winner. After reset port 1 counts as the last winner so
// port 0 takes the first tie.
module rr_arbiter_2
  import mem_arb_defs::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       grant_en_i,
  output logic       gnt_o
);

  logic r_last;
  logic w_gnt;

  // Tie goes to the port that did not win last; a lone requester always wins.
  always_comb begin
    w_gnt = PORT_CPU;
    if (req_i == 2'b11) w_gnt = ~r_last;
    else if (req_i[1])  w_gnt = PORT_DBG;
  end

  // Remember every grant actually taken, errored ones included.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)          r_last <= PORT_DBG;
    else if (grant_en_i) r_last <= w_gnt;
  end

  assign gnt_o = w_gnt;

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin sequencer in front of a single-ported synchronous data memory.
// One access at a time: IDLE arbitrates and latches the winner, ISSUE pulses
// the memory strobe, WAIT counts out the read latency, RESP returns the ack.
module data_memory_arbiter
  import mem_arb_defs::*;
#(
  parameter int DEPTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        ack_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_gnt;
  logic                r_we;
  logic [ADDR_W-3:0]   r_word;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_gnt;
  logic                w_grant_en;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_err;

  assign w_grant_en  = (r_state == IDLE) && (|req_i);
  assign w_sel_we    = w_gnt ? we_i[1]  : we_i[0];
  assign w_sel_addr  = w_gnt ? addr1_i  : addr0_i;
  assign w_sel_wdata = w_gnt ? wdata1_i : wdata0_i;
  // Misaligned byte address or word index past the end of memory.
  assign w_err = (w_sel_addr[1:0] != 2'b00) ||
                 ({2'b00, w_sel_addr[ADDR_W-1:2]} >= 32'(DEPTH));

  rr_arbiter_2 u_arb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .grant_en_i (w_grant_en),
    .gnt_o      (w_gnt)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state: errors skip the memory entirely, writes skip the wait.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (|req_i) w_state_next = w_err ? RESP : ISSUE;
      ISSUE: w_state_next = r_we ? RESP : WAIT;
      WAIT:  if (r_cnt == CNT_W'(1)) w_state_next = RESP;
      RESP:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Latch the winning request, run the latency counter, capture read data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_gnt   <= PORT_CPU;
      r_we    <= 1'b0;
      r_word  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_i) begin
            r_gnt   <= w_gnt;
            r_we    <= w_sel_we;
            r_word  <= w_sel_addr[ADDR_W-1:2];
            r_wdata <= w_sel_wdata;
            r_err   <= w_err;
            r_rdata <= '0;   // writes and errors report zero data
          end
        end
        ISSUE: if (!r_we) r_cnt <= LAT_LOAD;
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_rdata <= mem_rdata_i;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state so strobes and ack vanish at once on reset.
  always_comb begin
    mem_re_o    = (r_state == ISSUE) && !r_we;
    mem_we_o    = (r_state == ISSUE) &&  r_we;
    mem_addr_o  = {2'b00, r_word};
    mem_wdata_o = r_wdata;
    ack_o       = 2'b00;
    err_o       = 1'b0;
    rdata_o     = '0;
    if (r_state == RESP) begin
      ack_o   = port_onehot(r_gnt);
      err_o   = r_err;
      rdata_o = r_rdata;
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with DEPTH=8, LATENCY=3. A small
// memory model with a 3-stage read pipeline sits on the memory port; read
// data is only non-zero in the single cycle it is due.
module tb_data_memory_arbiter;

  localparam int LAT = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
  logic [1:0]  ack_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic        mem_re_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem_model [8] = '{default: '0};
  logic [31:0] rd_pipe [LAT] = '{default: '0};

  data_memory_arbiter #(.DEPTH(8), .LATENCY(LAT)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr0_i     (addr0_i),
    .addr1_i     (addr1_i),
    .wdata0_i    (wdata0_i),
    .wdata1_i    (wdata1_i),
    .ack_o       (ack_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .mem_re_o    (mem_re_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: write on strobe, read data delayed LAT cycles after issue.
  always @(posedge clk_i) begin
    if (mem_we_o) mem_model[mem_addr_o[2:0]] <= mem_wdata_o;
    rd_pipe[0] <= mem_re_o ? mem_model[mem_addr_o[2:0]] : 32'h0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata_i = rd_pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic set_port(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin addr0_i = a; wdata0_i = d; end
    else        begin addr1_i = a; wdata1_i = d; end
    we_i[p]  = w;
    req_i[p] = 1'b1;
  endtask

  // Single transaction from one port; checks strobe timing, ack latency and response.
  task automatic txn(input string tag, input int p, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input int exp_lat, input logic exp_err,
                     input logic [31:0] exp_rd);
    int n = 0;
    int strobes = 0;
    int strobe_cyc = -1;
    set_port(p, w, a, d);
    while (n < 20) begin
      tick();
      n++;
      if (mem_re_o || mem_we_o) begin
        strobes++;
        strobe_cyc = n;
        chk({tag, "_maddr"}, mem_addr_o, a >> 2);
        chk({tag, "_dir"}, {30'd0, mem_we_o, mem_re_o}, w ? 32'd2 : 32'd1);
        if (w) chk({tag, "_mwdata"}, mem_wdata_o, d);
      end
      if (ack_o != 2'b00) break;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_ack"}, {30'd0, ack_o}, (p == 0) ? 32'd1 : 32'd2);
    chk({tag, "_err"}, {31'd0, err_o}, {31'd0, exp_err});
    chk({tag, "_rdata"}, rdata_o, exp_rd);
    chk({tag, "_nstrobe"}, strobes, exp_err ? 0 : 1);
    if (!exp_err) chk({tag, "_strobe_cyc"}, strobe_cyc, 1);
    req_i[p] = 1'b0;
    tick();
  endtask

  // Both ports request writes continuously; grants must alternate from port 0.
  task automatic tie(input string tag, input int ntx, input int base, input logic [15:0] dtag);
    int issued = 2;
    int acks = 0;
    int since = 0;
    int both = 0;
    logic exp_p = 1'b0;
    int p;
    set_port(0, 1'b1, 32'((base + 0) * 4), {dtag, 16'd0});
    set_port(1, 1'b1, 32'((base + 1) * 4), {dtag, 16'd1});
    for (int cyc = 0; cyc < 40 && acks < ntx; cyc++) begin
      tick();
      since++;
      if (ack_o == 2'b11) both++;
      if (ack_o != 2'b00) begin
        chk({tag, "_port"}, {30'd0, ack_o}, exp_p ? 32'd2 : 32'd1);
        chk({tag, "_gap"}, since, (acks == 0) ? 2 : 3);
        p = ack_o[1] ? 1 : 0;
        if (issued < ntx) begin
          set_port(p, 1'b1, 32'((base + issued) * 4), {dtag, 16'(issued)});
          issued++;
        end else begin
          req_i[p] = 1'b0;
        end
        acks++;
        exp_p = ~exp_p;
        since = 0;
      end
    end
    chk({tag, "_nacks"}, acks, ntx);
    chk({tag, "_ack11"}, both, 0);
    req_i = 2'b00;
    tick();
  endtask

  initial begin
    int acks;
    int since;
    int ack_seen;
    int exp_word;
    rst_i = 1'b0;
    req_i = 2'b11;
    we_i = 2'b01;
    addr0_i = 32'h4; addr1_i = 32'h8;
    wdata0_i = 32'h1111_1111; wdata1_i = 32'h2222_2222;

    // Reset held with requests present.
    repeat (3) tick();
    chk("rst_ack", {30'd0, ack_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_strobes", {30'd0, mem_we_o, mem_re_o}, 32'd0);
    chk("rst_maddr", mem_addr_o, 32'd0);
    chk("rst_mwdata", mem_wdata_o, 32'd0);
    req_i = 2'b00;
    rst_i = 1'b1;
    tick();

    txn("wr0", 0, 1'b1, 32'h8, 32'hDEADBEEF, 2, 1'b0, 32'h0);
    txn("rd1", 1, 1'b0, 32'h8, 32'h0, 2 + LAT, 1'b0, 32'hDEADBEEF);
    tie("tie4", 4, 0, 16'hA1A1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("tie4_mem%0d", i), mem_model[i], {16'hA1A1, 16'(i)});

    txn("err_range", 0, 1'b0, 32'h20, 32'h0, 1, 1'b1, 32'h0);
    txn("err_align", 0, 1'b0, 32'h6, 32'h0, 1, 1'b1, 32'h0);

    // Reset during the read wait: strobes and ack must stay quiet.
    set_port(1, 1'b0, 32'h4, 32'h0);
    tick();
    chk("rmid_issue_re", {31'd0, mem_re_o}, 32'd1);
    tick();
    rst_i = 1'b0;
    #1;
    chk("rmid_strobes", {30'd0, mem_we_o, mem_re_o}, 32'd0);
    ack_seen = 0;
    repeat (2) begin tick(); if (ack_o != 2'b00) ack_seen++; end
    req_i = 2'b00;
    rst_i = 1'b1;
    repeat (6) begin tick(); if (ack_o != 2'b00 || mem_re_o || mem_we_o) ack_seen++; end
    chk("rmid_quiet", ack_seen, 0);
    tie("post_rst", 2, 0, 16'hB2B2);
    chk("post_rst_mem0", mem_model[0], 32'hB2B2_0000);
    chk("post_rst_mem1", mem_model[1], 32'hB2B2_0001);

    // Port 0 holds req high across acks, changing fields at each ack.
    acks = 0;
    since = 0;
    exp_word = 4;
    set_port(0, 1'b1, 32'd16, 32'h5A00_0004);
    for (int cyc = 0; cyc < 30 && acks < 3; cyc++) begin
      tick();
      since++;
      if (mem_we_o) chk("stream_maddr", mem_addr_o, 32'(exp_word));
      if (ack_o != 2'b00) begin
        chk("stream_ack", {30'd0, ack_o}, 32'd1);
        chk("stream_gap", since, (acks == 0) ? 2 : 3);
        acks++;
        since = 0;
        exp_word++;
        if (acks < 3) set_port(0, 1'b1, 32'(exp_word * 4), 32'h5A00_0000 | 32'(exp_word));
        else          req_i[0] = 1'b0;
      end
    end
    chk("stream_nacks", acks, 3);
    tick();
    for (int i = 4; i < 7; i++)
      chk($sformatf("stream_mem%0d", i), mem_model[i], 32'h5A00_0000 | 32'(i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Sequencer and two-way arbiter in front of the single-ported data memory. It shares the memory between the CPU load/store path (port 0) and the debug/program-loader path (port 1) using round-robin arbitration and a req/ack handshake. It drives one access at a time into a synchronous memory with a fixed read latency, then returns read data or an error to the winning requester.

## Interface
- `DEPTH`, 8: memory size in 32-bit words; valid word index is 0..DEPTH-1.
- `LATENCY`, 1: cycles from the issue cycle to valid `mem_rdata_i`; legal range is 1..7.
- `clk_i` input 1: the single clock.
- `rst_i` input 1: reset, asynchronous, active-low.
- `req_i` input [1:0]: request per port. Once raised, it is held with stable fields until that port's ack.
- `we_i` input [1:0]: per port, 1 = write, 0 = read.
- `addr0_i`, `addr1_i` input 32 each: byte address per port.
- `wdata0_i`, `wdata1_i` input 32 each: write data per port.
- `ack_o` output [1:0]: one-cycle completion pulse for the granted port.
- `err_o` output 1: valid with ack. Set for a misaligned or out-of-range address.
- `rdata_o` output 32: read data, valid with ack. It is 0 for writes and errors.
- `mem_re_o`, `mem_we_o` output 1 each: memory strobes, high for exactly one cycle per access.
- `mem_addr_o` output 32: word index, `addr[31:2]` zero-extended.
- `mem_wdata_o` output 32: write data.
- `mem_rdata_i` input 32: memory read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_i` bit is set, arbitrate and latch the winner's `we`, `addr` and `wdata` into internal registers. Grant is recorded in `gnt_q`.
  - If `addr[1:0]` != 0 or `addr[31:2]` >= DEPTH, go to RESP with the error bit set.
  - Otherwise go to ISSUE.
- **ISSUE**
  - Assert `mem_re_o` or `mem_we_o` with the latched address and data.
  - A write goes to RESP.
  - A read loads the wait counter with LATENCY and goes to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture `mem_rdata_i` into `rdata_q` and go to RESP.
- **RESP**
  - Pulse `ack_o[gnt_q]` and drive `err_o` and `rdata_o` from registers.
  - Always return to IDLE.
- **Round-robin**
  - `last_q` holds the port granted most recently.
  - If both ports request, grant `~last_q`. If one requests, grant it.
  - `last_q` updates on every grant, including errored ones.
- **Idle outputs:** all memory strobes are 0. `mem_addr_o` and `mem_wdata_o` hold their last values, and their value when no strobe is asserted is don't-care.
- **Invariant:** `ack_o` never has both bits set. Strobes are asserted only in ISSUE.

## Timing
- Let T be the IDLE cycle in which the request is sampled.
  - Write ack is at T+2.
  - Read ack is at T+2+LATENCY.
  - Error ack is at T+1, with no memory strobe.
- In its ack cycle the requester may still show `req_i` high. The following IDLE cycle ignores it only if the requester has dropped it. A requester keeping `req_i` high issues a new transaction.
- Back-to-back throughput: one access per 3 cycles for writes and per 3+LATENCY cycles for reads.
- Simultaneous requests in the same cycle are resolved by `last_q`. The loser keeps waiting, and its fields must stay stable.
- Reset values (asynchronous assertion):
  - State = IDLE.
  - `ack_o` = 0, `err_o` = 0, `rdata_o` = 0.
  - Strobes = 0, `mem_addr_o` = 0, `mem_wdata_o` = 0.
  - `last_q` = 1, so port 0 wins the first tie.
  - Counter = 0.
- Reset mid-transaction abandons it: no ack is produced, and strobes drop immediately.
- Deassertion of `rst_i` is synchronised externally. The first sample is taken at the first rising edge after release.

## Structure
- A shared package or include file `mem_arb_defs` holds the state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3), the port index constants PORT_CPU=0 and PORT_DBG=1, and the width constants.
- The arbitration logic lives in one sub-module, `rr_arbiter_2`:
  - Combinational grant from `req[1:0]` and `last`.
  - Registered `last` update gated by a `grant_en` input.
- The top-level contains the FSM, the wait counter, the latches and the output registers.

## Test plan
- **Reset:** hold `rst_i`=0 while driving requests → all outputs 0 and no strobes. Release, then port 0 writes 0xDEADBEEF to addr 0x8 → `mem_we_o` is high at T+1 with `mem_addr_o`=2, and `ack_o`=2'b01 at T+2.
- **Read latency:** with LATENCY=3, port 1 reads addr 0x8 → `mem_re_o` at T+1, `ack_o`=2'b10 at T+5, `rdata_o`=0xDEADBEEF.
- **Tie-break:** both ports request writes in the same cycle, for four consecutive transactions → grant order is 0,1,0,1, and `ack_o` is never 2'b11.
- **Errors:**
  - Port 0 reads addr 0x20 with DEPTH=8 → ack at T+1 with `err_o`=1, `rdata_o`=0, and no strobe.
  - Port 0 reads addr 0x6 → same error response.
- **Reset mid-operation:** assert `rst_i` during WAIT → no ack, and the FSM is back in IDLE. The next request completes normally with port 0 priority.
- **Stream:** port 0 holds `req_i` high across acks → one new access per 3 cycles for writes. The address is re-latched each time.
